// File: rtl/tangram_fb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tangram_fb_pkg
// Purpose : Shared framebuffer geometry and types for the scanout arbiter.
//           The framebuffer is 400x300 words of 4 bpp colour. Scanout upscales
//           it 2x2 onto an 800x600 raster.
// Revision: 1.0 - initial release
// ============================================================================
package tangram_fb_pkg;

    localparam int unsigned FB_W     = 400;
    localparam int unsigned FB_H     = 300;
    localparam int unsigned FB_DEPTH = FB_W * FB_H;

    typedef logic [16:0] fb_addr_t;
    typedef logic [3:0]  colour_t;

endpackage : tangram_fb_pkg
`default_nettype wire

// File: rtl/fb_scan_arbiter_sync_delay.sv
`default_nettype none
// ============================================================================
// Module  : sync_delay
// Purpose : N-stage shift register, W bits wide, with a per-bit reset value.
//           Used to re-align raster timing strobes and slot tags with data
//           coming back from the framebuffer RAM.
// Ports   : clk   - clock
//           rst   - synchronous active-high reset (loads RST_VAL into every stage)
//           d_i   - W-bit input
//           q_o   - W-bit input delayed by N cycles
// Revision: 1.0 - initial release
// ============================================================================
module sync_delay #(
    parameter int          W       = 1,
    parameter int          N       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q [N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < N; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[N-1];

endmodule : sync_delay
`default_nettype wire

// File: rtl/fb_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fb_scan_arbiter
// Purpose : Shares one single-port framebuffer RAM (1-cycle synchronous read)
//           between 2x2-upscaled display scanout and a drawing engine.
//           Scanout owns every even active pixel (de && !sx[0]); the writer
//           gets every other cycle through a valid/ready handshake. Timing
//           strobes are delayed so they line up with pix_colour.
// Config  : FB_ARB_VBLANK_WRITE_EN - when defined, writes are granted only
//           during vertical blanking (sy >= 600) for tear-free drawing.
// Ports   : clk_pix, rst_pix          - pixel clock, sync active-high reset
//           sx, sy, de, hsync, vsync,
//           frame                     - raster position / strobes in
//           wr_valid, wr_ready,
//           wr_addr, wr_data          - writer handshake
//           mem_addr, mem_we,
//           mem_wdata, mem_rdata      - framebuffer RAM port
//           pix_colour                - registered colour out
//           de_o, hsync_o, vsync_o,
//           frame_o                   - strobes delayed LAT cycles
//           wr_oob                    - sticky out-of-range write flag
// Revision: 1.0 - initial release
// ============================================================================
module fb_scan_arbiter
    import tangram_fb_pkg::*;
#(
    // The colour path is two register stages (RAM read + pix_colour); the
    // strobe delay must stay equal to it for the outputs to line up.
    parameter int LAT = 2
) (
    input  logic        clk_pix,
    input  logic        rst_pix,
    input  logic [9:0]  sx,
    input  logic [9:0]  sy,
    input  logic        de,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        frame,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [16:0] wr_addr,
    input  logic [3:0]  wr_data,
    output logic [16:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wdata,
    input  logic [3:0]  mem_rdata,
    output logic [3:0]  pix_colour,
    output logic        de_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        frame_o,
    output logic        wr_oob
);

    logic     disp_slot;
    logic     wr_slot;
    logic     xfer;
    logic     wr_in_range;
    fb_addr_t line_base_q, line_base_d;
    colour_t  pix_colour_q, pix_colour_d;
    logic     wr_oob_q, wr_oob_d;
    logic [1:0] tag_d1;      // {de, disp_slot} one cycle late
    logic [3:0] timing_dly;  // {de, hsync, vsync, frame} LAT cycles late

    // ------------------------------------------------------------------
    // Slot allocation
    // ------------------------------------------------------------------
    assign disp_slot = de && !sx[0];

`ifdef FB_ARB_VBLANK_WRITE_EN
    assign wr_slot = (sy >= 10'(2 * FB_H));
`else
    assign wr_slot = !disp_slot;
`endif

    assign wr_ready    = wr_slot && !rst_pix;
    assign xfer        = wr_valid && wr_ready;
    assign wr_in_range = (wr_addr < fb_addr_t'(FB_DEPTH));

    // ------------------------------------------------------------------
    // Line base: each framebuffer row is shown on two screen lines, so the
    // base advances by FB_W on every even line. line_base_d equals
    // line_base_q except on sx==0, where it already holds the new line's
    // base; addressing from it makes the first read of a line correct.
    // ------------------------------------------------------------------
    always_comb begin
        line_base_d = line_base_q;
        if (sx == 10'd0) begin
            if (sy == 10'd0) begin
                line_base_d = '0;
            end else if (!sy[0]) begin
                line_base_d = line_base_q + fb_addr_t'(FB_W);
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM port mux. Out-of-range writes are consumed but never reach the RAM.
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr = line_base_d;
        mem_we   = 1'b0;
        if (xfer) begin
            mem_addr = wr_addr;
            mem_we   = wr_in_range;
        end else if (disp_slot) begin
            mem_addr = line_base_d + fb_addr_t'(sx[9:1]);
        end
    end

    assign mem_wdata = wr_data;

    // ------------------------------------------------------------------
    // Colour pipeline. RAM data is only meaningful one cycle after a
    // display slot; on odd pixels the register holds, which duplicates the
    // even pixel horizontally. Blanking forces black.
    // ------------------------------------------------------------------
    sync_delay #(
        .W       (2),
        .N       (1),
        .RST_VAL (2'b00)
    ) u_tag_dly (
        .clk (clk_pix),
        .rst (rst_pix),
        .d_i ({de, disp_slot}),
        .q_o (tag_d1)
    );

    always_comb begin
        pix_colour_d = pix_colour_q;
        if (!tag_d1[1]) begin
            pix_colour_d = '0;
        end else if (tag_d1[0]) begin
            pix_colour_d = mem_rdata;
        end
    end

    assign wr_oob_d = wr_oob_q || (xfer && !wr_in_range);

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            line_base_q  <= '0;
            pix_colour_q <= '0;
            wr_oob_q     <= 1'b0;
        end else begin
            line_base_q  <= line_base_d;
            pix_colour_q <= pix_colour_d;
            wr_oob_q     <= wr_oob_d;
        end
    end

    // ------------------------------------------------------------------
    // Timing strobe alignment (sync pulses idle high)
    // ------------------------------------------------------------------
    sync_delay #(
        .W       (4),
        .N       (LAT),
        .RST_VAL (4'b0110)
    ) u_timing_dly (
        .clk (clk_pix),
        .rst (rst_pix),
        .d_i ({de, hsync, vsync, frame}),
        .q_o (timing_dly)
    );

    assign de_o       = timing_dly[3];
    assign hsync_o    = timing_dly[2];
    assign vsync_o    = timing_dly[1];
    assign frame_o    = timing_dly[0];
    assign pix_colour = pix_colour_q;
    assign wr_oob     = wr_oob_q;

endmodule : fb_scan_arbiter
`default_nettype wire

// File: tb/tb_fb_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fb_scan_arbiter
// Purpose : Directed self-checking bench for fb_scan_arbiter with a
//           behavioural 1-cycle synchronous-read RAM preloaded mem[k]=k%16.
//           Raster lines are compressed except a few full-width lines.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fb_scan_arbiter;

    logic        clk_pix;
    logic        rst_pix;
    logic [9:0]  sx, sy;
    logic        de, hsync, vsync, frame;
    logic        wr_valid;
    logic        wr_ready;
    logic [16:0] wr_addr;
    logic [3:0]  wr_data;
    logic [16:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wdata;
    logic [3:0]  mem_rdata;
    logic [3:0]  pix_colour;
    logic        de_o, hsync_o, vsync_o, frame_o;
    logic        wr_oob;

    int checks   = 0;
    int failures = 0;

    logic [3:0] mem [0:131071];

    // Strobe/position history for the alignment model
    logic h1_de, h1_hs, h1_vs, h1_fr, h2_de, h2_hs, h2_vs, h2_fr;
    int   h1_x, h1_y, h2_x, h2_y;

    fb_scan_arbiter dut (
        .clk_pix    (clk_pix),
        .rst_pix    (rst_pix),
        .sx         (sx),
        .sy         (sy),
        .de         (de),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame      (frame),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .pix_colour (pix_colour),
        .de_o       (de_o),
        .hsync_o    (hsync_o),
        .vsync_o    (vsync_o),
        .frame_o    (frame_o),
        .wr_oob     (wr_oob)
    );

    initial clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    initial begin
        for (int k = 0; k < 131072; k++) mem[k] = 4'(k % 16);
    end

    always @(posedge clk_pix) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic test_reset();
        rst_pix = 1'b1; sx = 10'd1; sy = 10'd0; de = 1'b1;
        hsync = 1'b0; vsync = 1'b0; frame = 1'b1;
        wr_valid = 1'b1; wr_addr = 17'd5; wr_data = 4'd3;
        for (int n = 0; n < 2; n++) begin
            tick();
            checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL rst_wr_ready got=%b want=0", wr_ready); end
            checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%b want=0", mem_we); end
        end
        checks++; if (pix_colour !== 4'd0) begin failures++; $display("FAIL rst_pix_colour got=%0d want=0", pix_colour); end
        checks++; if ({de_o, hsync_o, vsync_o, frame_o} !== 4'b0110) begin failures++;
            $display("FAIL rst_timing got=%b want=0110", {de_o, hsync_o, vsync_o, frame_o}); end
        checks++; if (wr_oob !== 1'b0) begin failures++; $display("FAIL rst_wr_oob got=%b want=0", wr_oob); end
        rst_pix = 1'b0; de = 1'b0; hsync = 1'b1; vsync = 1'b1; frame = 1'b0; wr_valid = 1'b0;
        sx = 10'd800;
        tick();
        tick();
    endtask

    task automatic test_frame();
        int nact, x, exp_a, aa, ea;
        logic ba, bt, bp;
        logic [3:0] epx, apx, wpx;
        logic [3:0] at, et;
        h1_de = 0; h1_hs = 1; h1_vs = 1; h1_fr = 0; h1_x = 0; h1_y = 0;
        h2_de = 0; h2_hs = 1; h2_vs = 1; h2_fr = 0; h2_x = 0; h2_y = 0;
        wr_valid = 1'b0;
        for (int y = 0; y < 628; y++) begin
            nact = (y <= 3 || y == 598 || y == 599) ? 800 : 4;
            ba = 0; bt = 0; bp = 0; aa = 0; ea = 0; apx = 0; wpx = 0; at = 0; et = 0;
            for (int k = 0; k < nact + 4; k++) begin
                x = (k < nact) ? k : (800 + k - nact);
                sx = 10'(x); sy = 10'(y);
                de = (y < 600) && (x < 800);
                hsync = !(x == 801 || x == 802);
                vsync = !(y >= 601 && y <= 604);
                frame = (y == 627) && (k == nact + 3);
                #1;
                exp_a = (y / 2) * 400 + ((de && (x % 2 == 0)) ? x / 2 : 0);
                if (!ba && (mem_addr !== 17'(exp_a) || mem_we !== 1'b0)) begin
                    ba = 1; aa = int'(mem_addr); ea = exp_a;
                end
                if (y == 2 && x == 0) begin
                    checks++; if (mem_addr !== 17'd400) begin failures++; $display("FAIL base_sy2 got=%0d want=400", mem_addr); end
                end
                if (y == 599 && x == 0) begin
                    checks++; if (mem_addr !== 17'd119600) begin failures++; $display("FAIL base_sy599 got=%0d want=119600", mem_addr); end
                end
                if (y == 599 && x == 798) begin
                    checks++; if (mem_addr !== 17'd119999) begin failures++; $display("FAIL last_read got=%0d want=119999", mem_addr); end
                end
                tick();
                h2_de = h1_de; h2_hs = h1_hs; h2_vs = h1_vs; h2_fr = h1_fr; h2_x = h1_x; h2_y = h1_y;
                h1_de = de; h1_hs = hsync; h1_vs = vsync; h1_fr = frame; h1_x = x; h1_y = y;
                epx = h2_de ? 4'(((h2_y / 2) * 400 + h2_x / 2) % 16) : 4'd0;
                if (!bt && {de_o, hsync_o, vsync_o, frame_o} !== {h2_de, h2_hs, h2_vs, h2_fr}) begin
                    bt = 1; at = {de_o, hsync_o, vsync_o, frame_o}; et = {h2_de, h2_hs, h2_vs, h2_fr};
                end
                if (!bp && pix_colour !== epx) begin
                    bp = 1; apx = pix_colour; wpx = epx;
                end
            end
            checks += 3;
            if (ba) begin failures++; $display("FAIL frame_addr sy=%0d got=%0d want=%0d", y, aa, ea); end
            if (bt) begin failures++; $display("FAIL frame_timing sy=%0d got=%b want=%b", y, at, et); end
            if (bp) begin failures++; $display("FAIL frame_pix sy=%0d got=%0d want=%0d", y, apx, wpx); end
        end
    endtask

    task automatic test_pixel();
        wr_valid = 1'b0; hsync = 1'b1; vsync = 1'b1; frame = 1'b0; de = 1'b1;
        sx = 10'd0; sy = 10'd0; tick();
        sx = 10'd0; sy = 10'd2; tick();
        for (int i = 0; i < 16; i++) begin
            sx = 10'(i); sy = 10'd4;
            #1;
            if (i == 10) begin
                checks++; if (mem_addr !== 17'd805) begin failures++; $display("FAIL pix_addr got=%0d want=805", mem_addr); end
            end
            tick();
            if (i == 11) begin
                checks++; if (pix_colour !== 4'd5 || de_o !== 1'b1) begin failures++;
                    $display("FAIL pix_sx10 got=%0d de_o=%b want=5 de_o=1", pix_colour, de_o); end
            end
            if (i == 12) begin
                checks++; if (pix_colour !== 4'd5) begin failures++; $display("FAIL pix_sx11 got=%0d want=5", pix_colour); end
            end
            if (i == 13) begin
                checks++; if (pix_colour !== 4'd6) begin failures++; $display("FAIL pix_sx12 got=%0d want=6", pix_colour); end
            end
        end
    endtask

`ifndef FB_ARB_VBLANK_WRITE_EN
    task automatic test_wr_wait();
        sy = 10'd6; sx = 10'd20; de = 1'b1;
        wr_valid = 1'b1; wr_addr = 17'd4660; wr_data = 4'd9;
        #1;
        checks++; if (wr_ready !== 1'b0 || mem_we !== 1'b0) begin failures++;
            $display("FAIL wr_sx20 ready=%b we=%b want ready=0 we=0", wr_ready, mem_we); end
        checks++; if (mem_addr !== 17'd810) begin failures++; $display("FAIL wr_sx20_addr got=%0d want=810", mem_addr); end
        tick();
        sx = 10'd21;
        #1;
        checks++; if (wr_ready !== 1'b1 || mem_we !== 1'b1) begin failures++;
            $display("FAIL wr_sx21 ready=%b we=%b want ready=1 we=1", wr_ready, mem_we); end
        checks++; if (mem_addr !== 17'd4660 || mem_wdata !== 4'd9) begin failures++;
            $display("FAIL wr_sx21_bus addr=%0d data=%0d want addr=4660 data=9", mem_addr, mem_wdata); end
        tick();
        wr_valid = 1'b0;
    endtask
`else
    task automatic test_vblank();
        sy = 10'd599; sx = 10'd21; de = 1'b1;
        wr_valid = 1'b1; wr_addr = 17'd4660; wr_data = 4'd9;
        #1;
        checks++; if (wr_ready !== 1'b0 || mem_we !== 1'b0) begin failures++;
            $display("FAIL vb_active ready=%b we=%b want 0 0", wr_ready, mem_we); end
        tick();
        sx = 10'd900; de = 1'b0;
        #1;
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL vb_hblank599 got=%b want=0", wr_ready); end
        tick();
        sy = 10'd600; sx = 10'd0;
        #1;
        checks++; if (wr_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 17'd4660) begin failures++;
            $display("FAIL vb_first_grant ready=%b we=%b addr=%0d want 1 1 4660", wr_ready, mem_we, mem_addr); end
        tick();
        wr_valid = 1'b0;
    endtask
`endif

    task automatic test_oob();
        sy = 10'd610; sx = 10'd900; de = 1'b0; hsync = 1'b1; vsync = 1'b1; frame = 1'b0;
        wr_valid = 1'b1; wr_addr = 17'd119999; wr_data = 4'd3;
        #1;
        checks++; if (wr_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 17'd119999) begin failures++;
            $display("FAIL wr_last ready=%b we=%b addr=%0d want 1 1 119999", wr_ready, mem_we, mem_addr); end
        tick();
        checks++; if (wr_oob !== 1'b0) begin failures++; $display("FAIL oob_after_last got=%b want=0", wr_oob); end
        wr_addr = 17'd120000; wr_data = 4'd7;
        #1;
        checks++; if (wr_ready !== 1'b1 || mem_we !== 1'b0) begin failures++;
            $display("FAIL oob_xfer ready=%b we=%b want ready=1 we=0", wr_ready, mem_we); end
        checks++; if (wr_oob !== 1'b0) begin failures++; $display("FAIL oob_early got=%b want=0", wr_oob); end
        tick();
        wr_valid = 1'b0;
        checks++; if (wr_oob !== 1'b1) begin failures++; $display("FAIL oob_set got=%b want=1", wr_oob); end
        tick(); tick(); tick();
        checks++; if (wr_oob !== 1'b1) begin failures++; $display("FAIL oob_sticky got=%b want=1", wr_oob); end
    endtask

    task automatic test_reset_mid();
        sy = 10'd8; de = 1'b1; hsync = 1'b0; vsync = 1'b0; frame = 1'b1;
        wr_valid = 1'b1; wr_addr = 17'd100; wr_data = 4'd1;
        for (int i = 30; i < 33; i++) begin
            sx = 10'(i);
            tick();
        end
        checks++; if (de_o !== 1'b1 || hsync_o !== 1'b0) begin failures++;
            $display("FAIL pre_rst de_o=%b hsync_o=%b want 1 0", de_o, hsync_o); end
        sx = 10'd33; rst_pix = 1'b1;
        #1;
        checks++; if (wr_ready !== 1'b0 || mem_we !== 1'b0) begin failures++;
            $display("FAIL mid_rst_wr ready=%b we=%b want 0 0", wr_ready, mem_we); end
        tick();
        checks++; if (pix_colour !== 4'd0 || wr_oob !== 1'b0) begin failures++;
            $display("FAIL mid_rst_state pix=%0d oob=%b want 0 0", pix_colour, wr_oob); end
        checks++; if ({de_o, hsync_o, vsync_o, frame_o} !== 4'b0110) begin failures++;
            $display("FAIL mid_rst_timing got=%b want=0110", {de_o, hsync_o, vsync_o, frame_o}); end
        rst_pix = 1'b0; hsync = 1'b1; vsync = 1'b1; frame = 1'b0; wr_valid = 1'b0;
        sx = 10'd34; tick();
        sx = 10'd35; tick();
        checks++; if (de_o !== 1'b1 || hsync_o !== 1'b1) begin failures++;
            $display("FAIL refill de_o=%b hsync_o=%b want 1 1", de_o, hsync_o); end
        de = 1'b0; sx = 10'd800;
        tick();
    endtask

    initial begin
        test_reset();
        test_frame();
        test_pixel();
`ifndef FB_ARB_VBLANK_WRITE_EN
        test_wr_wait();
`else
        test_vblank();
`endif
        test_oob();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fb_scan_arbiter
`default_nettype wire
